ksa_prefix_pipe: RTL and testbench
==================================

// Module: ksa_prefix_pipe
// PURPOSE
//  Consumer side of the Kogge-Stone P/G front end. Accepts bitwise propagate/generate
//  vectors (P=a^b, G=a&b) plus carry-in and runs the log2(WIDTH) Kogge-Stone prefix
//  levels, one register stage per level. It then forms sum = P ^ carries and carry-out.
//  Sits directly after the P/G layer. Provides the valid/ready pipelined 16-bit adder datapath.
// PARAMETERS
//  WIDTH   16              operand width; power of two, >=2
//  LEVELS  $clog2(WIDTH)   prefix levels (4 at WIDTH=16); derived, do not override
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      p_in/g_in/cin valid this cycle
//  in_ready   out  1      block can accept input this cycle
//  p_in       in   WIDTH  bitwise propagate vector
//  g_in       in   WIDTH  bitwise generate vector
//  cin        in   1      carry into bit 0
//  out_valid  out  1      sum/cout valid
//  out_ready  in   1      downstream accepts output
//  sum        out  WIDTH  P ^ {carry[WIDTH-1:1],cin}
//  cout       out  1      carry out of bit WIDTH-1
//  out_ovf    out  1      signed overflow (only with KSA_OVF_EN)
// BEHAVIOUR
//  - Reset: all stage valid bits 0. out_valid=0, sum=0, cout=0, out_ovf=0. in_ready=1 the cycle after reset.
//  - Stage 0 captures inputs and folds cin into bit 0: G0'=g0|(p0&cin).
//    The unmodified p_in and cin travel alongside every stage for the sum.
//  - Stage k (1..LEVELS), bit i, span d=2^(k-1):
//      i>=d: G=Gh|(Ph&Gl), P=Ph&Pl, where h=bit i and l=bit i-d of stage k-1
//      i<d : pass through
//  - Output stage registers sum=p^{G[WIDTH-2:0],cin} and cout=G[WIDTH-1].
//  - Latency: accept at edge T -> out_valid at edge T+LEVELS+1 (5 cycles at WIDTH=16).
//  - Throughput: one transfer per cycle when out_ready is held at 1.
//  - Global-stall pipeline: adv = ~out_valid | out_ready.
//    in_ready = adv (combinational from out_valid and out_ready).
//    All stages load only when adv=1. Bubbles are not collapsed.
//  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
//  - While out_valid=1 and out_ready=0: sum/cout/out_ovf are held stable and no stage changes.
//  - in_valid=0 while adv=1 inserts a bubble (stage valid=0). Data registers may load don't-care.
//  - Simultaneous output pop and input push in the same cycle is legal; full rate is kept.
//  - rst mid-operation: all in-flight items are dropped. Outputs return to reset values next edge.
//  - Unsigned wrap: the sum is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.
// CONFIGURATION
//  KSA_OVF_EN defined:
//    out_ovf port exists. out_ovf = cout ^ carry into MSB (= G[WIDTH-2], or cin when WIDTH... n/a, WIDTH>=2).
//    out_ovf is registered with sum and follows the same stall and reset rules.
//  KSA_OVF_EN undefined: out_ovf port and its logic are absent. No other change.
// STRUCTURE
//  - Package ksa_pkg:
//      KSA_WIDTH=16 and KSA_LEVELS=$clog2(KSA_WIDTH)
//      typedef pg_vec_t (logic [KSA_WIDTH-1:0])
//      typedef stage_t struct {valid, G, P, p_orig, cin}
//  - Sub-module ksa_black_cell (Gh,Ph,Gl,Pl -> G,P), instantiated via generate per bit per level.
//  - Stage registers are held in an array of stage_t indexed 0..LEVELS.
// TESTING
//  1 a=0xFFFF,b=0x0001 (p=0xFFFE,g=0x0001),cin=0 -> 5 cycles later sum=0x0000,cout=1
//  2 p=0x0000,g=0x0000,cin=1 -> sum=0x0001,cout=0; p=0xFFFF,g=0,cin=1 -> sum=0,cout=1
//  3 back-to-back stream of 100 random a,b,cin with out_ready=1:
//    one result per cycle, in order, each equal to a+b+cin
//  4 out_ready=0 for 7 cycles mid-stream:
//    out_valid/sum held, in_ready=0, no loss or duplication after release
//  5 rst asserted with 3 items in flight -> out_valid=0 next edge, none of the 3 ever emerge
//  6 (KSA_OVF_EN) a=0x7FFF,b=0x0001 -> sum=0x8000,out_ovf=1;
//    a=0xFFFF,b=0x0001 -> out_ovf=0

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared types for the Kogge-Stone prefix pipeline.
// Width, level count and the per-stage register bundle.
package ksa_pkg;

   localparam int KSA_WIDTH  = 16;
   localparam int KSA_LEVELS = $clog2(KSA_WIDTH);

   typedef logic [KSA_WIDTH-1:0] pg_vec_t;

   typedef struct packed {
      logic    valid;
      pg_vec_t g;
      pg_vec_t p;
      pg_vec_t p_orig;
      logic    cin;
   } stage_t;

endpackage

// File: rtl/ksa_black_cell.sv
// Kogge-Stone black cell.
// It combines a high group with the adjacent low group.
module ksa_black_cell (
   input  logic gh,
   input  logic ph,
   input  logic gl,
   input  logic pl,
   output logic g,
   output logic p
);

   assign g = gh | (ph & gl);
   assign p = ph & pl;

endmodule

// File: rtl/ksa_prefix_pipe.sv
// Pipelined Kogge-Stone prefix adder back end, one register per level.
// Optional signed overflow output is enabled by defining KSA_OVF_EN.
module ksa_prefix_pipe
   import ksa_pkg::*;
#(
   parameter int WIDTH  = KSA_WIDTH,
   parameter int LEVELS = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] p_in,
   input  logic [WIDTH-1:0] g_in,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef KSA_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   stage_t  st [0:LEVELS];
   pg_vec_t gn [1:LEVELS];
   pg_vec_t pn [1:LEVELS];
   pg_vec_t g0;
   logic    adv;
   logic    unused_p;

   // Every stage moves together; a stalled output freezes the whole pipe.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;
   assign unused_p = ^st[LEVELS].p;

   always_comb begin
      g0    = g_in;
      g0[0] = g_in[0] | (p_in[0] & cin);
   end

   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int D = 1 << (k - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= D) begin : g_cell
            ksa_black_cell u_cell (
               .gh (st[k-1].g[i]),
               .ph (st[k-1].p[i]),
               .gl (st[k-1].g[i-D]),
               .pl (st[k-1].p[i-D]),
               .g  (gn[k][i]),
               .p  (pn[k][i])
            );
         end else begin : g_pass
            assign gn[k][i] = st[k-1].g[i];
            assign pn[k][i] = st[k-1].p[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= LEVELS; k++) begin
            st[k] <= '0;
         end
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
`ifdef KSA_OVF_EN
         out_ovf   <= 1'b0;
`endif
      end else if (adv) begin
         st[0].valid  <= in_valid;
         st[0].g      <= g0;
         st[0].p      <= p_in;
         st[0].p_orig <= p_in;
         st[0].cin    <= cin;
         for (int k = 1; k <= LEVELS; k++) begin
            st[k].valid  <= st[k-1].valid;
            st[k].g      <= gn[k];
            st[k].p      <= pn[k];
            st[k].p_orig <= st[k-1].p_orig;
            st[k].cin    <= st[k-1].cin;
         end
         out_valid <= st[LEVELS].valid;
         sum       <= st[LEVELS].p_orig
                      ^ {st[LEVELS].g[WIDTH-2:0], st[LEVELS].cin};
         cout      <= st[LEVELS].g[WIDTH-1];
`ifdef KSA_OVF_EN
         // Carry into the MSB differs from carry out on signed overflow.
         out_ovf   <= st[LEVELS].g[WIDTH-1] ^ st[LEVELS].g[WIDTH-2];
`endif
      end
   end

endmodule

// File: tb/tb_ksa_prefix_pipe.sv
// Directed bench for ksa_prefix_pipe.
// Overflow checks are compiled in when KSA_OVF_EN is defined.
module tb_ksa_prefix_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] p_in;
   logic [15:0] g_in;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
`ifdef KSA_OVF_EN
   logic        out_ovf;
`endif

   int total = 0;
   int bad   = 0;
   logic [16:0] exp_q [$];

   always #5 clk = ~clk;

   ksa_prefix_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .p_in      (p_in),
      .g_in      (g_in),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef KSA_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   task automatic drive_stream(input int n);
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      bit          ok;
      int          guard;
      for (int i = 0; i < n; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         c = 1'($urandom_range(0, 1));
         p_in = a ^ b;
         g_in = a & b;
         cin = c;
         in_valid = 1'b1;
         ok = 1'b0;
         guard = 0;
         while (!ok && guard < 50) begin
            @(negedge clk);
            ok = (in_ready === 1'b1);
            @(posedge clk);
            #1;
            guard++;
         end
         if (ok) exp_q.push_back({1'b0, a} + {1'b0, b} + {16'd0, c});
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      p_in = '0;
      g_in = '0;
      cin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_valid got=%b want=0", out_valid);
      end
      total++;
      if ({cout, sum} !== 17'd0) begin
         bad++;
         $display("FAIL reset_data got=%h want=0", {cout, sum});
      end
`ifdef KSA_OVF_EN
      total++;
      if (out_ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset_ovf got=%b want=0", out_ovf);
      end
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready got=%b want=1", in_ready);
      end
   endtask

   task automatic test_vectors();
      logic [15:0] tp [6] = '{16'hFFFE, 16'h0000, 16'hFFFF,
                              16'h5115, 16'h0000, 16'h7FFE};
      logic [15:0] tg [6] = '{16'h0001, 16'h0000, 16'h0000,
                              16'h0220, 16'h8000, 16'h0001};
      logic        tc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [15:0] ts [6] = '{16'h0000, 16'h0001, 16'h0000,
                              16'h5555, 16'h0000, 16'h8000};
      logic        tco [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef KSA_OVF_EN
      logic        tov [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`endif
      int n;
      for (int v = 0; v < 6; v++) begin
         @(posedge clk);
         #1;
         p_in = tp[v];
         g_in = tg[v];
         cin = tc[v];
         in_valid = 1'b1;
         @(negedge clk);
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL vec%0d_ready got=%b want=1", v, in_ready);
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         n = 0;
         while (out_valid !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
         end
         total++;
         if (n != 5) begin
            bad++;
            $display("FAIL vec%0d_latency got=%0d want=5", v, n);
         end
         total++;
         if (sum !== ts[v]) begin
            bad++;
            $display("FAIL vec%0d_sum got=%h want=%h", v, sum, ts[v]);
         end
         total++;
         if (cout !== tco[v]) begin
            bad++;
            $display("FAIL vec%0d_cout got=%b want=%b", v, cout, tco[v]);
         end
`ifdef KSA_OVF_EN
         total++;
         if (out_ovf !== tov[v]) begin
            bad++;
            $display("FAIL vec%0d_ovf got=%b want=%b", v, out_ovf, tov[v]);
         end
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int got = 0;
      int cyc = 0;
      int first = -1;
      int last = -1;
      logic [16:0] e;
      exp_q.delete();
      out_ready = 1'b1;
      fork
         drive_stream(100);
         begin
            while (got < 100 && cyc < 200) begin
               @(negedge clk);
               cyc++;
               if (out_valid === 1'b1 && out_ready) begin
                  total++;
                  if (exp_q.size() == 0) begin
                     bad++;
                     $display("FAIL b2b_extra got=%h want=none", {cout, sum});
                  end else begin
                     e = exp_q.pop_front();
                     if ({cout, sum} !== e) begin
                        bad++;
                        $display("FAIL b2b_data got=%h want=%h", {cout, sum}, e);
                     end
                  end
                  if (first < 0) first = cyc;
                  last = cyc;
                  got++;
               end
            end
         end
      join
      total++;
      if (got != 100) begin
         bad++;
         $display("FAIL b2b_count got=%0d want=100", got);
      end
      total++;
      if (last - first != 99) begin
         bad++;
         $display("FAIL b2b_rate got=%0d want=99", last - first);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_stall();
      int got = 0;
      int cyc = 0;
      bit stalled = 1'b0;
      logic [16:0] e;
      logic [16:0] held;
      exp_q.delete();
      out_ready = 1'b1;
      fork
         drive_stream(30);
         begin
            while (got < 30 && cyc < 200) begin
               @(negedge clk);
               cyc++;
               if (out_valid === 1'b1 && out_ready) begin
                  total++;
                  if (exp_q.size() == 0) begin
                     bad++;
                     $display("FAIL stall_extra got=%h want=none", {cout, sum});
                  end else begin
                     e = exp_q.pop_front();
                     if ({cout, sum} !== e) begin
                        bad++;
                        $display("FAIL stall_data got=%h want=%h", {cout, sum}, e);
                     end
                  end
                  got++;
               end
               if (got == 10 && !stalled) begin
                  stalled = 1'b1;
                  @(posedge clk);
                  #1;
                  out_ready = 1'b0;
                  @(negedge clk);
                  held = {cout, sum};
                  for (int s = 0; s < 7; s++) begin
                     if (s > 0) @(negedge clk);
                     total++;
                     if (out_valid !== 1'b1 || {cout, sum} !== held) begin
                        bad++;
                        $display("FAIL stall_hold got=%b/%h want=1/%h",
                                 out_valid, {cout, sum}, held);
                     end
                     total++;
                     if (in_ready !== 1'b0) begin
                        bad++;
                        $display("FAIL stall_ready got=%b want=0", in_ready);
                     end
                  end
                  @(posedge clk);
                  #1;
                  out_ready = 1'b1;
               end
            end
         end
      join
      total++;
      if (got != 30 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL stall_count got=%0d want=30", got);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_flight();
      bit seen = 1'b0;
      exp_q.delete();
      out_ready = 1'b1;
      drive_stream(3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || {cout, sum} !== 17'd0) begin
         bad++;
         $display("FAIL flush_now got=%b/%h want=0/0", out_valid, {cout, sum});
      end
      rst = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL flush_leak got=1 want=0");
      end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_stall();
      test_reset_flight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
